// File: rtl/fft_butterfly_stage_pkg.sv
// Shared constants and helpers for the radix-2 butterfly datapath (Q1.15).
package fft_pkg;

    localparam int          DW      = 16;
    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    // Clamp an 18-bit two's-complement value into the Q1.15 range.
    // The value fits in 16 bits exactly when its top three bits agree.
    function automatic logic [15:0] sat16(input logic [17:0] v);
        logic [15:0] r;
        if (v[17:15] == 3'b000 || v[17:15] == 3'b111) begin
            r = v[15:0];
        end else if (v[17]) begin
            r = Q15_MIN;
        end else begin
            r = Q15_MAX;
        end
        return r;
    endfunction

    // Sign-extend a Q1.15 word to 18 bits for headroom in the add/sub.
    function automatic logic [17:0] sxt18(input logic [15:0] v);
        return {{2{v[15]}}, v};
    endfunction

endpackage

// File: rtl/complex_twiddle_mult.sv
// Complex product p = b * W built from four real Q1.15 multipliers.
// Results are 17 bits wide so the add/sub never wraps.
module complex_twiddle_mult
    import fft_pkg::*;
(
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    input  logic [DW-1:0] w_re,
    input  logic [DW-1:0] w_im,
    output logic [DW:0]   p_re,
    output logic [DW:0]   p_im
);

    logic [DW-1:0] m0;
    logic [DW-1:0] m1;
    logic [DW-1:0] m2;
    logic [DW-1:0] m3;

    q15_mult u_m0 (.a(b_re), .b(w_re), .p(m0));
    q15_mult u_m1 (.a(b_im), .b(w_im), .p(m1));
    q15_mult u_m2 (.a(b_re), .b(w_im), .p(m2));
    q15_mult u_m3 (.a(b_im), .b(w_re), .p(m3));

    // Combine the partial products with one guard bit each.
    always_comb begin
        p_re = {m0[DW-1], m0} - {m1[DW-1], m1};
        p_im = {m2[DW-1], m2} + {m3[DW-1], m3};
    end

endmodule

// File: rtl/q15_mult.sv
// Q1.15 multiplier: sign-magnitude product, re-signed, keeping bits [30:15].
// Negating after the magnitude product makes negative results round away
// from zero, which is the floor-like behaviour the datapath is built around.
module q15_mult
    import fft_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] p
);

    logic [DW-1:0]   mag_a;
    logic [DW-1:0]   mag_b;
    logic [2*DW-1:0] mag_p;
    logic [2*DW-1:0] signed_p;
    logic            neg;
    logic            unused_bits;

    // Form magnitudes, multiply, re-apply the sign and take the Q1.15 slice.
    always_comb begin
        mag_a    = a[DW-1] ? (~a + 16'd1) : a;
        mag_b    = b[DW-1] ? (~b + 16'd1) : b;
        mag_p    = {16'd0, mag_a} * {16'd0, mag_b};
        neg      = a[DW-1] ^ b[DW-1];
        signed_p = neg ? (~mag_p + 32'd1) : mag_p;
        p        = signed_p[30:15];
    end

    assign unused_bits = ^{signed_p[31], signed_p[14:0]};

endmodule

// File: rtl/fft_butterfly_stage.sv
// Three-stage pipelined radix-2 DIT butterfly with valid/ready flow control.
// S1 registers the inputs, S2 holds b*W and a, S3 holds the scaled,
// saturated sum and difference. A single enable stalls every stage together.
module fft_butterfly_stage
    import fft_pkg::*;
#(
    parameter logic SCALE = 1'b1
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    input  logic [DW-1:0] w_re,
    input  logic [DW-1:0] w_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] x_re,
    output logic [DW-1:0] x_im,
    output logic [DW-1:0] y_re,
    output logic [DW-1:0] y_im
);

    logic          v1;
    logic          v2;
    logic          v3;
    logic          en;

    logic [DW-1:0] s1_a_re;
    logic [DW-1:0] s1_a_im;
    logic [DW-1:0] s1_b_re;
    logic [DW-1:0] s1_b_im;
    logic [DW-1:0] s1_w_re;
    logic [DW-1:0] s1_w_im;

    logic [DW-1:0] s2_a_re;
    logic [DW-1:0] s2_a_im;
    logic [DW:0]   s2_p_re;
    logic [DW:0]   s2_p_im;

    logic [DW:0]   p_re;
    logic [DW:0]   p_im;

    logic [17:0]   sum_re;
    logic [17:0]   sum_im;
    logic [17:0]   dif_re;
    logic [17:0]   dif_im;

    // Halve (floor) when scaling is enabled, then clamp into Q1.15.
    function automatic logic [15:0] finish(input logic [17:0] s);
        logic [15:0] r;
        if (SCALE) begin
            r = sat16({s[17], s[17:1]});
        end else begin
            r = sat16(s);
        end
        return r;
    endfunction

    assign en        = !v3 || out_ready;
    assign in_ready  = en;
    assign out_valid = v3;

    complex_twiddle_mult u_cmul (
        .b_re (s1_b_re),
        .b_im (s1_b_im),
        .w_re (s1_w_re),
        .w_im (s1_w_im),
        .p_re (p_re),
        .p_im (p_im)
    );

    // Butterfly add/sub with 18-bit headroom ahead of the S3 registers.
    always_comb begin
        sum_re = sxt18(s2_a_re) + {s2_p_re[DW], s2_p_re};
        sum_im = sxt18(s2_a_im) + {s2_p_im[DW], s2_p_im};
        dif_re = sxt18(s2_a_re) - {s2_p_re[DW], s2_p_re};
        dif_im = sxt18(s2_a_im) - {s2_p_im[DW], s2_p_im};
    end

    // Advance valids and data one stage on enable; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_a_re <= '0;
            s1_a_im <= '0;
            s1_b_re <= '0;
            s1_b_im <= '0;
            s1_w_re <= '0;
            s1_w_im <= '0;
            s2_a_re <= '0;
            s2_a_im <= '0;
            s2_p_re <= '0;
            s2_p_im <= '0;
            x_re    <= '0;
            x_im    <= '0;
            y_re    <= '0;
            y_im    <= '0;
        end else if (en) begin
            v1      <= in_valid;
            v2      <= v1;
            v3      <= v2;
            s1_a_re <= a_re;
            s1_a_im <= a_im;
            s1_b_re <= b_re;
            s1_b_im <= b_im;
            s1_w_re <= w_re;
            s1_w_im <= w_im;
            s2_a_re <= s1_a_re;
            s2_a_im <= s1_a_im;
            s2_p_re <= p_re;
            s2_p_im <= p_im;
            x_re    <= finish(sum_re);
            x_im    <= finish(sum_im);
            y_re    <= finish(dif_re);
            y_im    <= finish(dif_im);
        end
    end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Scoreboard bench for fft_butterfly_stage: one scaled and one unscaled
// instance share stimulus; an integer reference model predicts both.
module tb_fft_butterfly_stage;

    typedef struct {
        logic [15:0] s1_xr, s1_xi, s1_yr, s1_yi;
        logic [15:0] s0_xr, s0_xi, s0_yr, s0_yi;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;

    logic        in_ready1, out_valid1;
    logic [15:0] x_re1, x_im1, y_re1, y_im1;
    logic        in_ready0, out_valid0;
    logic [15:0] x_re0, x_im0, y_re0, y_im0;

    int          total = 0;
    int          bad = 0;
    int          cycle_count = 0;
    bit          latency_check = 0;
    exp_t        sb[$];

    bit          hold_pending = 0;
    logic [15:0] hold_vals[8];

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    fft_butterfly_stage #(.SCALE(1'b1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid1), .out_ready(out_ready),
        .x_re(x_re1), .x_im(x_im1), .y_re(y_re1), .y_im(y_im1)
    );

    fft_butterfly_stage #(.SCALE(1'b0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .x_re(x_re0), .x_im(x_im0), .y_re(y_re0), .y_im(y_im0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle_count);
        end
    endtask

    // Q1.15 product as real numbers: |u*v|/2^15, floored for positive
    // results and rounded away from zero for negative ones.
    function automatic int qmul(input logic [15:0] u, input logic [15:0] v);
        int su, sv, mag;
        su  = int'($signed(u));
        sv  = int'($signed(v));
        mag = (su < 0 ? -su : su) * (sv < 0 ? -sv : sv);
        if ((su < 0) != (sv < 0)) return -((mag + 32767) / 32768);
        return mag / 32768;
    endfunction

    function automatic logic [15:0] finish_model(input int s, input bit scale);
        int v;
        logic [31:0] w;
        v = scale ? (s >>> 1) : s;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        w = v;
        return w[15:0];
    endfunction

    function automatic exp_t model(input logic [15:0] ar, ai, br, bi, wr, wi);
        exp_t e;
        int pr, pi, sar, sai;
        pr  = qmul(br, wr) - qmul(bi, wi);
        pi  = qmul(br, wi) + qmul(bi, wr);
        sar = int'($signed(ar));
        sai = int'($signed(ai));
        e.s1_xr = finish_model(sar + pr, 1'b1);
        e.s1_xi = finish_model(sai + pi, 1'b1);
        e.s1_yr = finish_model(sar - pr, 1'b1);
        e.s1_yi = finish_model(sai - pi, 1'b1);
        e.s0_xr = finish_model(sar + pr, 1'b0);
        e.s0_xi = finish_model(sai + pi, 1'b0);
        e.s0_yr = finish_model(sar - pr, 1'b0);
        e.s0_yi = finish_model(sai - pi, 1'b0);
        e.cyc   = 0;
        return e;
    endfunction

    function automatic logic [15:0] rand16();
        logic [31:0] r;
        r = $urandom;
        return r[15:0];
    endfunction

    function automatic logic [15:0] randw();
        logic [15:0] r;
        r = rand16();
        if (r == 16'h8000) r = 16'h8001;
        return r;
    endfunction

    // Monitor/scoreboard: records accepted beats and checks every output
    // transfer, stall stability and flow-control rules on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            hold_pending = 0;
        end else begin
            checkOutput("in_ready_rule", {31'd0, in_ready1}, {31'd0, (!out_valid1 || out_ready)});
            checkOutput("in_ready_match", {31'd0, in_ready0}, {31'd0, in_ready1});
            checkOutput("out_valid_match", {31'd0, out_valid0}, {31'd0, out_valid1});
            if (hold_pending) begin
                checkOutput("hold_valid", {31'd0, out_valid1}, 32'd1);
                checkOutput("hold_data", {x_re1, x_im1, y_re1, y_im1, x_re0, x_im0, y_re0, y_im0} == {hold_vals[0], hold_vals[1], hold_vals[2], hold_vals[3], hold_vals[4], hold_vals[5], hold_vals[6], hold_vals[7]}, 32'd1);
            end
            hold_pending = 0;
            if (out_valid1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    checkOutput("s1_x_re", x_re1, e.s1_xr);
                    checkOutput("s1_x_im", x_im1, e.s1_xi);
                    checkOutput("s1_y_re", y_re1, e.s1_yr);
                    checkOutput("s1_y_im", y_im1, e.s1_yi);
                    checkOutput("s0_x_re", x_re0, e.s0_xr);
                    checkOutput("s0_x_im", x_im0, e.s0_xi);
                    checkOutput("s0_y_re", y_re0, e.s0_yr);
                    checkOutput("s0_y_im", y_im0, e.s0_yi);
                    if (latency_check) checkOutput("latency", cycle_count - e.cyc, 32'd3);
                end else begin
                    hold_vals[0] = x_re1; hold_vals[1] = x_im1; hold_vals[2] = y_re1; hold_vals[3] = y_im1;
                    hold_vals[4] = x_re0; hold_vals[5] = x_im0; hold_vals[6] = y_re0; hold_vals[7] = y_im0;
                    hold_pending = 1;
                end
            end
            if (in_valid && in_ready1) begin
                e = model(a_re, a_im, b_re, b_im, w_re, w_im);
                e.cyc = cycle_count;
                sb.push_back(e);
            end
        end
    end

    // Drive one beat for a single cycle; assumes the pipeline can accept.
    task automatic applyStimulus(input logic [15:0] ar, ai, br, bi, wr, wi);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic randomize_inputs();
        a_re = rand16(); a_im = rand16();
        b_re = rand16(); b_im = rand16();
        w_re = randw();  w_im = randw();
    endtask

    initial begin
        bit acc;
        int idx;
        logic [15:0] beats[8][6];

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        randomize_inputs();

        // Reset held for two cycles with in_valid asserted.
        @(posedge clk); #1;
        checkOutput("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready1}, 32'd1);
        checkOutput("rst_xy", {x_re1, x_im1, y_re1, y_im1}, 64'd0);
        @(posedge clk); #1;
        checkOutput("rst_out_valid2", {31'd0, out_valid0}, 32'd0);
        checkOutput("rst_xy0", {x_re0, y_re0}, 32'd0);
        checkOutput("rst_in_ready2", {31'd0, in_ready0}, 32'd1);
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Directed vectors, latency checked by both the bench and monitor.
        latency_check = 1;
        applyStimulus(16'h2000, 16'h0000, 16'h1000, 16'h0000, 16'h7FFF, 16'h0000);
        checkOutput("d1_not_early", {31'd0, out_valid1}, 32'd0);
        repeat (2) @(posedge clk); #1;
        checkOutput("d1_valid", {31'd0, out_valid1}, 32'd1);
        checkOutput("d1_x_re", x_re1, 16'h17FF);
        checkOutput("d1_y_re", y_re1, 16'h0800);
        checkOutput("d1_im", {x_im1, y_im1}, 32'd0);
        repeat (3) @(posedge clk); #1;

        applyStimulus(16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h8001);
        repeat (2) @(posedge clk); #1;
        checkOutput("d2_x", {x_re1, x_im1}, {16'h0000, 16'hE000});
        checkOutput("d2_y", {y_re1, y_im1}, {16'h0000, 16'h2000});
        repeat (3) @(posedge clk); #1;

        applyStimulus(16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000);
        repeat (2) @(posedge clk); #1;
        checkOutput("d3_x_re_sat", x_re0, 16'h7FFF);
        checkOutput("d3_y_re", y_re0, 16'h0001);
        repeat (3) @(posedge clk); #1;
        latency_check = 0;

        // Eight back-to-back beats with the consumer stalled in cycles 4..7.
        for (int i = 0; i < 8; i++) begin
            beats[i][0] = rand16(); beats[i][1] = rand16(); beats[i][2] = rand16();
            beats[i][3] = rand16(); beats[i][4] = randw();  beats[i][5] = randw();
        end
        idx = 0; acc = 0;
        for (int k = 0; k < 20; k++) begin
            if (k != 0) begin
                @(posedge clk); #1;
            end
            if (acc) idx++;
            in_valid = (idx < 8);
            if (idx < 8) begin
                a_re = beats[idx][0]; a_im = beats[idx][1]; b_re = beats[idx][2];
                b_im = beats[idx][3]; w_re = beats[idx][4]; w_im = beats[idx][5];
            end
            out_ready = !(k >= 4 && k <= 7);
            @(negedge clk);
            acc = in_valid && in_ready1;
            checkOutput($sformatf("stall_in_ready_k%0d", k), {31'd0, in_ready1}, {31'd0, !(k >= 4 && k <= 7)});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        checkOutput("stall_beats_sent", idx, 32'd8);
        checkOutput("stall_drained", sb.size(), 32'd0);

        // Reset pulse with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("midrst_out_valid", {31'd0, out_valid1}, 32'd0);
        checkOutput("midrst_out_valid0", {31'd0, out_valid0}, 32'd0);
        latency_check = 1;
        applyStimulus(rand16(), rand16(), rand16(), rand16(), randw(), randw());
        repeat (6) @(posedge clk); #1;
        latency_check = 0;
        checkOutput("midrst_drained", sb.size(), 32'd0);

        // Random traffic with random back-pressure.
        for (int k = 0; k < 300; k++) begin
            randomize_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("final_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
